// File: rtl/baud_gen_pkg.sv
// Shared types, constants and helpers for the programmable baud generator.
package baud_gen_pkg;

  // Width of the oversample slot index presented to uart_rx.
  localparam int unsigned OVS_IDX_W  = 4;
  localparam int unsigned CFG_DIV_W  = 20;
  localparam int unsigned CFG_FRAC_W = 4;

  // Divisor as written by the register block.
  typedef struct packed {
    logic [CFG_DIV_W-1:0]  div;
    logic [CFG_FRAC_W-1:0] frac;
  } baud_cfg_t;

  // Divisor reload handshake states.
  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StDone
  } cfg_state_e;

  // Clocks per rx tick minus one for a given clock, baud rate and oversample factor.
  function automatic int unsigned default_div(input int unsigned freq,
                                              input int unsigned baud,
                                              input int unsigned ovs);
    return (freq / (baud * ovs)) - 1;
  endfunction

endpackage

// File: rtl/baud_tick_div.sv
// Loadable rx tick divider. Optional fractional stretch under BAUD_GEN_FRAC_EN.
module baud_tick_div #(
  parameter int unsigned      DIV_W   = 20,
  parameter int unsigned      FRAC_W  = 4,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [DIV_W-1:0]  load_div,
  input  logic [FRAC_W-1:0] load_frac,
  output logic              tick_now,
  output logic              tick
);
  import baud_gen_pkg::*;

  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic             run_q, tick_q;
  logic             counting, at_end, stretch;

  // run_q delays counting by one clock so the first tick lands div+1 clocks after enable.
  assign counting = enable && run_q;
  assign at_end   = counting && (cnt_q == div_q);

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_d, acc_q, acc_d;
  logic              stretch_q, stretch_d;

  assign stretch = stretch_q;

  // Accumulate the fraction at each tick; a carry holds the counter one extra clock.
  always_comb begin
    frac_d    = frac_q;
    acc_d     = acc_q;
    stretch_d = stretch_q;
    if (!enable) begin
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (at_end) begin
      if (stretch_q) begin
        stretch_d = 1'b0;
      end else begin
        {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_q};
      end
    end
    if (load) begin
      frac_d    = load_frac;
      acc_d     = '0;
      stretch_d = 1'b0;
    end
  end

  // Fractional state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q    <= '0;
      acc_q     <= '0;
      stretch_q <= 1'b0;
    end else begin
      frac_q    <= frac_d;
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^load_frac;
  assign stretch     = 1'b0;
`endif

  assign tick_now = at_end && !stretch;

  // Counter next state; a stretched end-of-period simply holds the count.
  always_comb begin
    div_d = load ? load_div : div_q;
    cnt_d = cnt_q;
    if (!enable || tick_now) begin
      cnt_d = '0;
    end else if (counting && !at_end) begin
      cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter, active divisor and registered tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      tick_q <= 1'b0;
    end else begin
      run_q  <= enable;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_now;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/baud_gen_prog.sv
// Runtime-programmable baud tick generator: rx oversample tick, phase-locked tx bit tick,
// divisor reload via valid/ready. Optional fractional divisor: define BAUD_GEN_FRAC_EN.
module baud_gen_prog #(
  parameter int unsigned FREQUENCY  = 10000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DIV_W      = 20,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              rx_bd_en,
  output logic              tx_bd_en,
  output logic [3:0]        rx_idx
);
  import baud_gen_pkg::*;

  localparam logic [DIV_W-1:0] DIV0 =
    DIV_W'(default_div(FREQUENCY, BAUD_RATE, OVERSAMPLE));
  localparam logic [OVS_IDX_W-1:0] IDX_LAST = OVS_IDX_W'(OVERSAMPLE - 1);

  cfg_state_e            state_q, state_d;
  logic                  ready_q, load, tick_now, tx_q, tx_d;
  logic [DIV_W-1:0]      sh_div_q;
  logic [FRAC_W-1:0]     sh_frac_q;
  logic [OVS_IDX_W-1:0]  idx_q, idx_d;

  baud_tick_div #(
    .DIV_W   (DIV_W),
    .FRAC_W  (FRAC_W),
    .DIV_RST (DIV0)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .load_div  (sh_div_q),
    .load_frac (sh_frac_q),
    .tick_now  (tick_now),
    .tick      (rx_bd_en)
  );

  // Handshake: a pending divisor loads on the next tick edge, or at once while disabled.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: if (cfg_valid) state_d = StPend;
      StPend: begin
        if (!enable || tick_now) begin
          load    = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake state, shadow divisor and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      sh_div_q  <= '0;
      sh_frac_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle);
      if (state_q == StIdle && cfg_valid) begin
        sh_div_q  <= cfg_div;
        sh_frac_q <= cfg_frac;
      end
    end
  end

  // Oversample slot counter; tx tick rides on the rx tick that wraps the slot to 0.
  always_comb begin
    idx_d = idx_q;
    tx_d  = 1'b0;
    if (!enable) begin
      idx_d = '0;
    end else if (tick_now) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        tx_d  = 1'b1;
      end else begin
        idx_d = idx_q + OVS_IDX_W'(1);
      end
    end
  end

  // Slot index and tx tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      tx_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      tx_q  <= tx_d;
    end
  end

  assign cfg_ready = ready_q;
  assign tx_bd_en  = tx_q;
  assign rx_idx    = idx_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Directed bench for baud_gen_prog (defaults: 10 MHz, 115200, OVS 8, DIV0 = 9).
module tb_baud_gen_prog;

  logic        clk, rst, enable, cfg_valid, cfg_ready;
  logic [19:0] cfg_div;
  logic [3:0]  cfg_frac;
  logic        rx_bd_en, tx_bd_en;
  logic [3:0]  rx_idx;

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;
  int dead;
  int total;

  baud_gen_prog #(
    .FREQUENCY  (10000000),
    .BAUD_RATE  (115200),
    .OVERSAMPLE (8),
    .DIV_W      (20),
    .FRAC_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_frac  (cfg_frac),
    .rx_bd_en  (rx_bd_en),
    .tx_bd_en  (tx_bd_en),
    .rx_idx    (rx_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next rx tick, checks its distance and the slot/tx model.
  task automatic wait_rx(input string tag, input int exp_gap);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rx_bd_en !== 1'b1 && n < 200);
    chk(tag, n, exp_gap);
    exp_idx = (exp_idx + 1) % 8;
    chk({tag, "_idx"}, rx_idx, exp_idx);
    chk({tag, "_tx"}, tx_bd_en, (exp_idx == 0) ? 1 : 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_frac = '0;
    repeat (3) @(negedge clk);
    chk("rst_rx", rx_bd_en, 0);
    chk("rst_tx", tx_bd_en, 0);
    chk("rst_idx", rx_idx, 0);
    chk("rst_ready", cfg_ready, 1);

    // Defaults: first tick 10 clks after enable sampled, then every 10, tx every 8th.
    rst = 1'b0;
    @(negedge clk);
    chk("en_no_tick", rx_bd_en, 0);
    wait_rx("first_tick", 10);
    for (int i = 0; i < 7; i++) wait_rx("div9_period", 10);

    // Mid-period load of 3, offered 5 clks after a tick; a second offer while busy is ignored.
    repeat (4) @(negedge clk);
    cfg_div = 20'd3; cfg_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready_low", cfg_ready, 0);
    cfg_div = 20'd7;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("busy_ready_low", cfg_ready, 0);
    wait_rx("old_period_end", 4);
    chk("load_ready_low", cfg_ready, 0);
    @(negedge clk);
    chk("ready_back", cfg_ready, 1);
    wait_rx("div3_period_a", 3);
    wait_rx("div3_period_b", 4);

    // cfg_div = 0: continuous rx ticks.
    cfg_div = 20'd0; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_rx("load_div0", 3);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      exp_idx = (exp_idx + 1) % 8;
      chk("div0_rx", rx_bd_en, 1);
      chk("div0_idx", rx_idx, exp_idx);
      chk("div0_tx", tx_bd_en, (exp_idx == 0) ? 1 : 0);
    end

    // Reload of 9 landing on the wrap tick still emits tx.
    cfg_div = 20'd9; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("wrap_pre_idx", rx_idx, 7);
    chk("wrap_pre_ready", cfg_ready, 0);
    @(negedge clk);
    chk("wrap_load_rx", rx_bd_en, 1);
    chk("wrap_load_tx", tx_bd_en, 1);
    chk("wrap_load_idx", rx_idx, 0);
    @(negedge clk);
    chk("wrap_ready", cfg_ready, 1);
    chk("wrap_gap_rx", rx_bd_en, 0);
    exp_idx = 0;
    wait_rx("reload9_first", 9);
    for (int i = 0; i < 4; i++) wait_rx("reload9_period", 10);

    // Disable at slot 5: quiet for 20 clks.
    enable = 1'b0;
    dead = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_bd_en !== 1'b0 || tx_bd_en !== 1'b0 || rx_idx !== 4'd0) dead++;
    end
    chk("disabled_quiet", dead, 0);

    // Load while disabled: next cycle, ready one cycle later.
    cfg_div = 20'd4; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("dis_accept_ready", cfg_ready, 0);
    @(negedge clk);
    chk("dis_load_ready", cfg_ready, 0);
    @(negedge clk);
    chk("dis_ready_back", cfg_ready, 1);

    // Re-enable restarts phase with the new divisor.
    enable = 1'b1;
    @(negedge clk);
    chk("reen_idx", rx_idx, 0);
    chk("reen_rx", rx_bd_en, 0);
    exp_idx = 0;
    wait_rx("reen_first", 5);
    wait_rx("reen_period", 5);

    // Reset mid-period and mid-handshake.
    repeat (2) @(negedge clk);
    cfg_div = 20'd2; cfg_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_ready", cfg_ready, 0);
    cfg_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rx", rx_bd_en, 0);
    chk("mid_rst_tx", tx_bd_en, 0);
    chk("mid_rst_idx", rx_idx, 0);
    chk("mid_rst_ready", cfg_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cfg_ready, 1);
    exp_idx = 0;
    wait_rx("post_rst_first", 10);
    wait_rx("post_rst_period", 10);

`ifdef BAUD_GEN_FRAC_EN
    // div 9, frac 8/16: periods alternate 10 and 11.
    cfg_div = 20'd9; cfg_frac = 4'd8; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_rx("frac_load", 9);
    wait_rx("frac_p0", 10);
    wait_rx("frac_p1", 10);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rx_bd_en !== 1'b1 && n < 200);
      total += n;
      chk("frac_alt", n, (i % 2 == 0) ? 11 : 10);
    end
    chk("frac_16_ticks", total, 168);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
